// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake
// and resolves the next PC from decoder branch flags on retire.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        br_jal,
    input  logic        br_beq,
    input  logic        br_blt,
    input  logic        br_bltu,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    input  logic        halt,
    output logic        misalign_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;

    // The fetch address is the PC register itself; it only moves on retire.
    assign imem_addr = pc;

    always_comb begin
        taken = br_jal
              | (br_beq  & (rs1_val == rs2_val))
              | (br_blt  & ($signed(rs1_val) < $signed(rs2_val)))
              | (br_bltu & (rs1_val < rs2_val));
        target  = inst_pc + imm;
        next_pc = taken ? {target[31:2], 2'b00} : inst_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            inst         <= NOP_INST;
            inst_pc      <= RESET_PC;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
            retire_cnt   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!halt) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state      <= HOLD;
                        imem_req   <= 1'b0;
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc         <= next_pc;
                        inst       <= NOP_INST;
                        inst_valid <= 1'b0;
                        retire_cnt <= retire_cnt + 32'd1;
                        if (taken && (target[1:0] != 2'b00))
                            misalign_err <= 1'b1;
                        state    <= halt ? IDLE : REQ;
                        imem_req <= !halt;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front-end stage directly upstream of the instruction control decoder in the single-period RISC-V core.
- Owns the PC and fetches instruction words from instruction memory over a req/ack handshake. Holds each word stable for the decoder/execute path until execute accepts it.
- Resolves the next PC from the decoder's branch flags (br_jal, br_beq, br_blt, br_bltu), the register-file operands and the immediate.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on inst when no instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch word address (byte address, [1:0]=0).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- inst  out  32  instruction to decoder.
- inst_pc  out  32  PC of inst.
- inst_valid  out  1  inst/inst_pc hold a fetched instruction.
- inst_ready  in  1  execute retires inst this cycle.
- br_jal, br_beq, br_blt, br_bltu  in  1 each  branch-type flags from decoder (for inst).
- rs1_val, rs2_val  in  32 each  register operands of inst.
- imm  in  32  sign-extended B/J immediate of inst.
- halt  in  1  stop issuing new fetches.
- misalign_err  out  1  sticky: a taken target had [1:0]!=0.
- retire_cnt  out  32  count of retired instructions.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - inst=NOP_INST, inst_pc=RESET_PC, inst_valid=0.
  - misalign_err=0, retire_cnt=0.
- States:
  - IDLE: imem_req=0. Go to REQ on the first edge where halt=0.
  - REQ: imem_req=1, imem_addr=pc.
    - On an edge with imem_ack=1: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD.
    - Ack is sampled only while imem_req=1; an ack in IDLE/HOLD is ignored.
    - A request is never abandoned: halt does not cancel REQ.
  - HOLD: imem_req=0; inst, inst_pc and inst_valid are stable.
    - On an edge with inst_ready=1:
      - pc<=next_pc; inst_valid<=0; inst<=NOP_INST.
      - retire_cnt<=retire_cnt+1, wrapping 2^32-1 to 0.
      - Go to REQ if halt=0, else IDLE.
- Latency: ack-to-inst_valid is 1 edge; retire-to-next-imem_req is 1 edge. Peak throughput is 1 instruction per 2 cycles with zero-wait memory (ack in the first REQ cycle).
- Branch resolution uses only HOLD-cycle inputs:
  - taken = br_jal | (br_beq & rs1_val==rs2_val) | (br_blt & signed(rs1_val)<signed(rs2_val)) | (br_bltu & rs1_val<rs2_val).
  - target = inst_pc + imm, mod 2^32.
  - next_pc = taken ? {target[31:2],2'b00} : inst_pc+4. Wrap from 32'hFFFF_FFFC goes to 0.
  - If taken and target[1:0]!=0: misalign_err<=1 (sticky until reset); execution continues at the truncated address.
  - Multiple branch flags set at once: taken if any term is true (OR); no error.
- inst_ready while inst_valid=0 is ignored: no retire, no count.
- halt=1 during REQ: complete the fetch, enter HOLD, then go to IDLE on retire.
- Reset mid-fetch: state drops to IDLE immediately. A late imem_ack after reset is ignored.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: release rst_n; zero-wait memory; inst_ready=1; no branch flags.
  - Response: imem_addr sequence 0x0,0x4,0x8; inst_valid high every 2nd cycle; retire_cnt=3 after 3 retires.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Response: imem_req held high 4 cycles with constant addr; inst_valid rises exactly 1 edge after ack; no duplicate fetch.
- Branches at inst_pc=0x100, imm=0xFFFF_FFF0:
  - beq with rs1=rs2=5 -> next addr 0xF0.
  - blt with rs1=0xFFFF_FFFF, rs2=1 -> 0xF0.
  - bltu with the same operands -> 0x104 (not taken).
  - jal -> 0xF0.
- Misalignment:
  - Stimulus: jal, inst_pc=0x20, imm=0x6.
  - Response: next imem_addr=0x24; misalign_err=1 and stays 1 through later retires until rst_n=0.
- Halt and backpressure:
  - Stimulus: halt=1 during REQ; inst_ready=0 for 5 cycles.
  - Response: inst and inst_pc stable for 5 cycles. After retire, state is IDLE with imem_req=0. halt=0 resumes fetch at next_pc.
- Async reset mid-fetch:
  - Stimulus: rst_n low while imem_req=1, then ack arrives.
  - Response: all outputs immediately at reset values; ack ignored; first post-reset fetch is from RESET_PC.
